counter_bank_display: RTL and testbench
=======================================

// Module: counter_bank_display
// PURPOSE
//  Parametrised successor to the single button counter: NCH independent WIDTH-bit
//  up/down counters stepped by one debounced push-button. Button input is raw,
//  active-low. The channel chosen by sel is stepped, cleared and shown on a
//  multiplexed DIGITS-digit hex 7-segment display. Sits directly under top; top
//  maps btn0 to rst, btn1 to btn_n and switches to sel/dir/clr.
// PARAMETERS
//  CLKFREQ     27000000  clk frequency in Hz
//  NCH         4         number of counter channels (>=1, power of 2)
//  WIDTH       16        counter width in bits (1..DIGITS*4)
//  DIGITS      4         number of 7-seg digits scanned
//  DEBOUNCE_MS 10        required stable time of button, ms (>=1)
//  REFRESH_HZ  1000      full-display refresh rate, Hz
// PORTS
//  clk       in   1                 system clock
//  rst       in   1                 asynchronous reset, active-high
//  btn_n     in   1                 raw count button, active-low, asynchronous
//  sel       in   max(1,clog2 NCH)  channel select for step/clear/display
//  dir       in   1                 0 = count up, 1 = count down
//  clr       in   1                 synchronous clear of selected channel (level)
//  digits    out  DIGITS            digit enables, active-low, one-hot-zero
//  segments  out  8                 {dp,g,f,e,d,c,b,a}, active-low, dp always 1
//  dat       out  WIDTH             registered value of selected channel
//  wrap      out  1                 1-cycle pulse when a step over/underflows
// BEHAVIOUR
//  Reset (async assert, sync release):
//  - all channels 0, dat=0, wrap=0, debounce FSM=IDLE
//  - scan index 0: digits=~1 (digit0 on), segments=8'hC0 ('0')
//  Input sync: btn_n, sel, dir and clr pass through 2 FFs before use.
//  Debounce FSM, DEB=CLKFREQ/1000*DEBOUNCE_MS cycles:
//  - IDLE:     synced btn low -> ARM, cnt cleared
//  - ARM:      btn high -> IDLE; else cnt==DEB-1 -> PRESSED, emit step (1 cycle)
//  - PRESSED:  btn high -> RELEASE, cnt cleared
//  - RELEASE:  btn low -> PRESSED; else cnt==DEB-1 -> IDLE
//  - Exactly one step per accepted press; holding the button never repeats.
//  - Glitches shorter than DEB cycles produce no step.
//  Counter update (cycle after step, uses synced sel/dir):
//  - dir=0: ch[sel] <= ch[sel]+1; dir=1: ch[sel] <= ch[sel]-1 (mod 2^WIDTH)
//  - wrap=1 that cycle if all-ones->0 (up) or 0->all-ones (down)
//  - clr has priority over step: ch[sel]<=0, no wrap, step discarded
//  - unselected channels hold
//  - dat <= ch[sel_sync] every cycle; 1-cycle latency from channel update or
//    sel change
//  Display:
//  - scan counter ticks every CLKFREQ/(REFRESH_HZ*DIGITS) cycles (min 1)
//  - index runs 0..DIGITS-1 then wraps to 0
//  - digit i shows nibble i of dat zero-extended to DIGITS*4; glyphs 0-F
//  - digits and segments registered, change on the same edge (no ghosting)
//  Boundaries:
//  - sel changed mid-debounce: the step goes to sel sampled at step time
//  - rst mid-press: FSM IDLE; a button still held counts only after release and
//    a new press
// TESTING (CLKFREQ=4000, DEBOUNCE_MS=1 -> DEB=4, NCH=4, WIDTH=8, DIGITS=2)
//  1 Reset: rst=1 -> dat=0, wrap=0, digits=2'b10, segments=8'hC0; held after
//    release.
//  2 Press: btn_n low 20 cycles, sel=2, dir=0 -> ch2=1 exactly once, dat=8'h01;
//    ch0/1/3 remain 0.
//  3 Bounce: btn_n pulses low 3 cycles x5 with 1-cycle highs -> no change; then
//    a clean 10-cycle low -> +1.
//  4 Wrap: ch1 preset to 8'hFF via 255 presses, one more press -> dat=8'h00 and
//    a 1-cycle wrap. dir=1, press -> dat=8'hFF, wrap pulses again.
//  5 Clear vs step: clr=1 held across an accepted press on sel=2 -> ch2=0,
//    wrap=0, other channels intact.
//  6 Scan: dat=8'h3A -> digit0 active shows 8'h88 ('A'), digit1 shows 8'hB0
//    ('3'); the enable rotates every 1 tick; rst mid-press behaves as in
//    Boundaries.

Source files
------------

// File: rtl/counter_bank_display.sv
// Bank of NCH up/down counters stepped by one debounced active-low button, with the
// selected channel shown on a multiplexed hex 7-segment display.
module counter_bank_display #(
    parameter int CLKFREQ     = 27000000,
    parameter int NCH         = 4,
    parameter int WIDTH       = 16,
    parameter int DIGITS      = 4,
    parameter int DEBOUNCE_MS = 10,
    parameter int REFRESH_HZ  = 1000,
    localparam int SELW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_n,
    input  logic [SELW-1:0]   sel,
    input  logic              dir,
    input  logic              clr,
    output logic [DIGITS-1:0] digits,
    output logic [7:0]        segments,
    output logic [WIDTH-1:0]  dat,
    output logic              wrap
);

    localparam int DEB_RAW  = CLKFREQ / 1000 * DEBOUNCE_MS;
    localparam int DEB      = (DEB_RAW < 1) ? 1 : DEB_RAW;
    localparam int CNTW     = (DEB > 1) ? $clog2(DEB) : 1;
    localparam int TICK_RAW = CLKFREQ / (REFRESH_HZ * DIGITS);
    localparam int TICK     = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int TW       = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int IDXW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(DEB - 1);
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK - 1);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        PRESSED,
        RELEASE
    } deb_state_t;

    logic            btn_s1, btn_s2;
    logic [SELW-1:0] sel_s1, sel_s2;
    logic            dir_s1, dir_s2;
    logic            clr_s1, clr_s2;
    logic            seen_release;

    deb_state_t      state, next_state;
    logic [CNTW-1:0] cnt, next_cnt;
    logic            step;
    logic            btn_low;

    logic [WIDTH-1:0] ch [NCH];
    logic [SELW-1:0]  chan;

    logic [TW-1:0]         tick_cnt;
    logic [IDXW-1:0]       idx;
    logic [DIGITS*4-1:0]   dat_ext;
    logic [3:0]            nibble;

    // Button sync resets to "pressed" so a button held through reset is never taken as a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            sel_s1 <= '0;
            sel_s2 <= '0;
            dir_s1 <= 1'b0;
            dir_s2 <= 1'b0;
            clr_s1 <= 1'b0;
            clr_s2 <= 1'b0;
            seen_release <= 1'b0;
        end else begin
            btn_s1 <= btn_n;
            btn_s2 <= btn_s1;
            sel_s1 <= sel;
            sel_s2 <= sel_s1;
            dir_s1 <= dir;
            dir_s2 <= dir_s1;
            clr_s1 <= clr;
            clr_s2 <= clr_s1;
            if (btn_s2)
                seen_release <= 1'b1;
        end
    end

    assign btn_low = ~btn_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (btn_low && seen_release) begin
                    next_state = ARM;
                    next_cnt   = '0;
                end
            end
            ARM: begin
                if (!btn_low) begin
                    next_state = IDLE;
                end else if (cnt == CNT_LAST) begin
                    next_state = PRESSED;
                    step       = 1'b1;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_low) begin
                    next_state = RELEASE;
                    next_cnt   = '0;
                end
            end
            RELEASE: begin
                if (btn_low)
                    next_state = PRESSED;
                else if (cnt == CNT_LAST)
                    next_state = IDLE;
                else
                    next_cnt = cnt + 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    assign chan = (NCH > 1) ? sel_s2 : '0;

    // Clear wins over a coinciding step; the step is simply dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++)
                ch[i] <= '0;
            dat  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clr_s2) begin
                ch[chan] <= '0;
            end else if (step) begin
                if (dir_s2) begin
                    ch[chan] <= ch[chan] - 1'b1;
                    wrap     <= (ch[chan] == '0);
                end else begin
                    ch[chan] <= ch[chan] + 1'b1;
                    wrap     <= (ch[chan] == '1);
                end
            end
            dat <= ch[chan];
        end
    end

    function automatic logic [7:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 8'hC0;
            4'h1: glyph = 8'hF9;
            4'h2: glyph = 8'hA4;
            4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;
            4'h5: glyph = 8'h92;
            4'h6: glyph = 8'h82;
            4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;
            4'h9: glyph = 8'h90;
            4'hA: glyph = 8'h88;
            4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;
            4'hD: glyph = 8'hA1;
            4'hE: glyph = 8'h86;
            default: glyph = 8'h8E;
        endcase
    endfunction

    assign dat_ext = (DIGITS*4)'(dat);
    assign nibble  = 4'(dat_ext >> {idx, 2'b00});

    // Enable and glyph are registered from the same index so they switch together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            idx      <= '0;
            digits   <= ~DIGITS'(1);
            segments <= 8'hC0;
        end else begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            digits   <= ~(DIGITS'(1) << idx);
            segments <= glyph(nibble);
        end
    end

endmodule

// File: tb/tb_counter_bank_display.sv
// Self-checking bench for counter_bank_display: constant vectors, hand-written corner
// sequences and randomized presses against an array model of the channels.
module tb_counter_bank_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_n;
    logic [1:0] sel;
    logic       dir;
    logic       clr;
    logic [1:0] digits;
    logic [7:0] segments;
    logic [7:0] dat;
    logic       wrap;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model [4];

    typedef struct {
        logic [1:0] sel;
        logic       dir;
        logic       clr;
        logic [7:0] exp_dat;
        int         exp_wraps;
    } vec_t;

    vec_t vecs [7];

    counter_bank_display #(
        .CLKFREQ(4000),
        .NCH(4),
        .WIDTH(8),
        .DIGITS(2),
        .DEBOUNCE_MS(1),
        .REFRESH_HZ(1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_n(btn_n),
        .sel(sel),
        .dir(dir),
        .clr(clr),
        .digits(digits),
        .segments(segments),
        .dat(dat),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One press: button low for low_cyc cycles then high for high_cyc, counting wrap pulses.
    task automatic applyStimulus(input logic [1:0] s, input logic d, input logic c,
                                 input int low_cyc, input int high_cyc, output int wraps);
        sel   = s;
        dir   = d;
        clr   = c;
        wraps = 0;
        btn_n = 1'b0;
        repeat (low_cyc) begin
            @(negedge clk);
            if (wrap) wraps++;
        end
        btn_n = 1'b1;
        repeat (high_cyc) begin
            @(negedge clk);
            if (wrap) wraps++;
        end
        clr = 1'b0;
    endtask

    task automatic modelPress(input logic [1:0] s, input logic d, input logic c, output int exp_wraps);
        exp_wraps = 0;
        if (c) begin
            model[s] = 8'h00;
        end else if (d) begin
            if (model[s] == 8'h00) exp_wraps = 1;
            model[s] = model[s] - 8'd1;
        end else begin
            if (model[s] == 8'hFF) exp_wraps = 1;
            model[s] = model[s] + 8'd1;
        end
    endtask

    task automatic sweepChannels(input string tag);
        for (int c = 0; c < 4; c++) begin
            sel = 2'(c);
            repeat (4) @(negedge clk);
            checkOutput($sformatf("%s_ch%0d", tag, c), 32'(dat), 32'(model[c]));
        end
    endtask

    task automatic clearChannel(input logic [1:0] s);
        sel = s;
        clr = 1'b1;
        repeat (5) @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);
        model[s] = 8'h00;
    endtask

    initial begin
        int w;
        int ew;
        int total;
        logic [1:0] dg [8];
        logic [7:0] sg [8];
        logic [7:0] exp_seg;

        vecs[0] = '{sel: 2'd2, dir: 1'b0, clr: 1'b0, exp_dat: 8'h01, exp_wraps: 0};
        vecs[1] = '{sel: 2'd0, dir: 1'b1, clr: 1'b0, exp_dat: 8'hFF, exp_wraps: 1};
        vecs[2] = '{sel: 2'd0, dir: 1'b0, clr: 1'b0, exp_dat: 8'h00, exp_wraps: 1};
        vecs[3] = '{sel: 2'd3, dir: 1'b0, clr: 1'b0, exp_dat: 8'h01, exp_wraps: 0};
        vecs[4] = '{sel: 2'd3, dir: 1'b0, clr: 1'b0, exp_dat: 8'h02, exp_wraps: 0};
        vecs[5] = '{sel: 2'd2, dir: 1'b0, clr: 1'b1, exp_dat: 8'h00, exp_wraps: 0};
        vecs[6] = '{sel: 2'd3, dir: 1'b1, clr: 1'b0, exp_dat: 8'h01, exp_wraps: 0};

        for (int c = 0; c < 4; c++) model[c] = 8'h00;

        rst   = 1'b1;
        btn_n = 1'b1;
        sel   = 2'd0;
        dir   = 1'b0;
        clr   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_dat", 32'(dat), 32'h00);
        checkOutput("reset_wrap", 32'(wrap), 32'h0);
        checkOutput("reset_digits", 32'(digits), 32'h2);
        checkOutput("reset_segments", 32'(segments), 32'hC0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_dat", 32'(dat), 32'h00);
        checkOutput("post_reset_digits", 32'(digits), 32'h2);
        checkOutput("post_reset_segments", 32'(segments), 32'hC0);
        repeat (6) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].dir, vecs[i].clr, 20, 10, w);
            modelPress(vecs[i].sel, vecs[i].dir, vecs[i].clr, ew);
            checkOutput($sformatf("vec%0d_dat", i), 32'(dat), 32'(vecs[i].exp_dat));
            checkOutput($sformatf("vec%0d_wrap", i), 32'(w), 32'(vecs[i].exp_wraps));
        end
        sweepChannels("table");

        sel   = 2'd2;
        dir   = 1'b0;
        total = 0;
        for (int k = 0; k < 5; k++) begin
            btn_n = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (wrap) total++;
            end
            btn_n = 1'b1;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        checkOutput("bounce_no_step", 32'(dat), 32'(model[2]));
        applyStimulus(2'd2, 1'b0, 1'b0, 10, 10, w);
        modelPress(2'd2, 1'b0, 1'b0, ew);
        checkOutput("bounce_clean_press", 32'(dat), 32'(model[2]));

        clearChannel(2'd1);
        total = 0;
        for (int k = 0; k < 255; k++) begin
            applyStimulus(2'd1, 1'b0, 1'b0, 8, 8, w);
            modelPress(2'd1, 1'b0, 1'b0, ew);
            total += w;
        end
        checkOutput("preset_ff_dat", 32'(dat), 32'hFF);
        checkOutput("preset_no_wrap", 32'(total), 32'd0);
        applyStimulus(2'd1, 1'b0, 1'b0, 10, 10, w);
        modelPress(2'd1, 1'b0, 1'b0, ew);
        checkOutput("overflow_dat", 32'(dat), 32'h00);
        checkOutput("overflow_wrap", 32'(w), 32'd1);
        applyStimulus(2'd1, 1'b1, 1'b0, 10, 10, w);
        modelPress(2'd1, 1'b1, 1'b0, ew);
        checkOutput("underflow_dat", 32'(dat), 32'hFF);
        checkOutput("underflow_wrap", 32'(w), 32'd1);

        for (int k = 0; k < 40; k++) begin
            logic [1:0] s;
            logic d;
            logic c;
            s = 2'($urandom_range(0, 3));
            d = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 7) == 0);
            applyStimulus(s, d, c, $urandom_range(8, 16), $urandom_range(8, 16), w);
            modelPress(s, d, c, ew);
            checkOutput($sformatf("rand%0d_dat", k), 32'(dat), 32'(model[s]));
            checkOutput($sformatf("rand%0d_wrap", k), 32'(w), 32'(ew));
        end
        sweepChannels("random");

        clearChannel(2'd3);
        for (int k = 0; k < 58; k++) begin
            applyStimulus(2'd3, 1'b0, 1'b0, 8, 8, w);
            modelPress(2'd3, 1'b0, 1'b0, ew);
        end
        checkOutput("scan_dat", 32'(dat), 32'h3A);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            dg[k] = digits;
            sg[k] = segments;
        end
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("scan_onehot%0d", k), 32'(dg[k] == 2'b10 || dg[k] == 2'b01), 32'd1);
            exp_seg = (dg[k] == 2'b10) ? 8'h88 : 8'hB0;
            checkOutput($sformatf("scan_glyph%0d", k), 32'(sg[k]), 32'(exp_seg));
        end
        for (int k = 0; k < 6; k++)
            checkOutput($sformatf("scan_rotate%0d", k), 32'(dg[k+2]), 32'({dg[k][0], dg[k][1]}));

        sel   = 2'd0;
        dir   = 1'b0;
        btn_n = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) model[c] = 8'h00;
        total = 0;
        repeat (30) begin
            @(negedge clk);
            if (wrap) total++;
        end
        checkOutput("rst_held_no_step", 32'(dat), 32'h00);
        checkOutput("rst_held_no_wrap", 32'(total), 32'd0);
        btn_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("rst_release_no_step", 32'(dat), 32'h00);
        applyStimulus(2'd0, 1'b0, 1'b0, 10, 10, w);
        modelPress(2'd0, 1'b0, 1'b0, ew);
        checkOutput("rst_new_press", 32'(dat), 32'h01);
        sweepChannels("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
